// File: rtl/tdc_stream_tx_pkg.sv
// Shared constants, widths and FSM encoding for the TDC stream transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdc_stream_tx_pkg;

    // Width of a counter that must hold values 0..n-1, never narrower than 1 bit.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NP         = 10;
    localparam int PIXEL_NUM  = 3;
    localparam int DATA_NUM   = 2;
    localparam int ACQ_NUM    = 2;
    localparam int PASS_NUM   = 2;
    localparam int GAP_CYCLES = 4;

    localparam int WORDS_PER_ACQ = PIXEL_NUM * DATA_NUM;
    localparam int ACQ_W         = WORDS_PER_ACQ * NP;

    localparam int WC_W   = cw(WORDS_PER_ACQ);
    localparam int AC_W   = cw(ACQ_NUM);
    localparam int GC_W   = cw(GAP_CYCLES);
    localparam int PASS_W = cw(PASS_NUM);

    typedef logic [NP-1:0]    word_t;
    typedef logic [ACQ_W-1:0] snap_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/tdc_stream_tx_if.sv
// Snapshot-in / word-stream-out bundle of the TDC stream transmitter.
// Latency: n/a (wiring only).
// Backpressure: acqReady on the snapshot side; the word stream has none.
interface tdc_stream_tx_if;
    import tdc_stream_tx_pkg::*;

    logic              acqValid;
    logic              acqReady;
    snap_t             acqData;
    logic              wrEn;
    word_t             data;
    logic [PASS_W-1:0] passIdx;
    logic              passDone;
    logic              frameDone;
    logic              overflow;
    logic              busy;

    // Capture side / environment
    modport master (
        output acqValid, acqData,
        input  acqReady, wrEn, data, passIdx, passDone, frameDone, overflow, busy
    );

    // Transmitter
    modport slave (
        input  acqValid, acqData,
        output acqReady, wrEn, data, passIdx, passDone, frameDone, overflow, busy
    );

endinterface

// File: rtl/tdc_stream_tx_acq_dbuf.sv
// Shadow/active snapshot double buffer with a word-select read port on the active copy.
// Latency: accept and transfer each take effect on the edge where they are asserted.
// Backpressure: full blocks new accepts; a request while full is ignored here (the caller flags the drop).
module acq_dbuf
    import tdc_stream_tx_pkg::*;
(
    input  logic            clk,
    input  logic            res,
    input  logic            in_vld,
    input  snap_t           in_dat,
    input  logic            xfer,
    input  logic [WC_W-1:0] sel,
    output logic            full,
    output word_t           word_dat
);

    snap_t shadow;
    snap_t active;

    // Shadow slot: filled on accept, released when the FSM takes it; the two never coincide
    // because a transfer needs full=1 while an accept needs full=0.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            shadow <= '0;
            full   <= 1'b0;
        end else if (in_vld && !full) begin
            shadow <= in_dat;
            full   <= 1'b1;
        end else if (xfer) begin
            full   <= 1'b0;
        end
    end

    // Active slot: reloaded from the shadow on every transfer.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            active <= '0;
        end else if (xfer) begin
            active <= shadow;
        end
    end

    // Pick word (p,d) of the active snapshot; sel walks pixel-major, then data index.
    always_comb begin
        word_dat = '0;
        for (int i = 0; i < WORDS_PER_ACQ; i++) begin
            if (sel == i[WC_W-1:0]) begin
                word_dat = active[i*NP +: NP];
            end
        end
    end

endmodule

// File: rtl/tdc_stream_tx.sv
// Serializes TDC snapshots into a one-word-per-cycle stream, ACQ_NUM acqs per pass, gap after each pass.
// Latency: accept at edge t (idle, shadow empty) -> first wrEn cycle after edge t+2; 1 word/clk in SEND.
// Backpressure: acqReady = shadow empty; snapshots offered while not ready are dropped and flagged sticky.
module tdc_stream_tx
    import tdc_stream_tx_pkg::*;
(
    input  logic           clk,
    input  logic           res,
    tdc_stream_tx_if.slave s
);

    state_t            state;
    state_t            state_nxt;
    logic [WC_W-1:0]   word_cnt;
    logic [AC_W-1:0]   acq_cnt;
    logic [GC_W-1:0]   gap_cnt;
    logic [PASS_W-1:0] pass_idx;
    logic              full;
    logic              xfer;
    logic              last_word;
    logic              last_acq;
    logic              gap_end;
    word_t             word_dat;
    word_t             data_q;
    logic              wr_en_q;
    logic              pass_done_q;
    logic              frame_done_q;
    logic              overflow_q;

    acq_dbuf u_dbuf (
        .clk      (clk),
        .res      (res),
        .in_vld   (s.acqValid),
        .in_dat   (s.acqData),
        .xfer     (xfer),
        .sel      (word_cnt),
        .full     (full),
        .word_dat (word_dat)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and shadow->active transfer; back-to-back acquisitions chain without a bubble.
    always_comb begin
        state_nxt = state;
        xfer      = 1'b0;
        last_word = (word_cnt == WC_W'(WORDS_PER_ACQ - 1));
        last_acq  = (acq_cnt == AC_W'(ACQ_NUM - 1));
        gap_end   = (gap_cnt == GC_W'(GAP_CYCLES - 1));
        case (state)
            IDLE: begin
                if (full) begin
                    xfer      = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (last_word) begin
                    if (last_acq) begin
                        state_nxt = GAP;
                    end else if (full) begin
                        xfer = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word, acquisition, gap and pass counters.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            word_cnt <= '0;
            acq_cnt  <= '0;
            gap_cnt  <= '0;
            pass_idx <= '0;
        end else begin
            if (xfer || (state == SEND && last_word)) begin
                word_cnt <= '0;
            end else if (state == SEND) begin
                word_cnt <= word_cnt + WC_W'(1);
            end

            if (state == SEND && last_word && !last_acq) begin
                acq_cnt <= acq_cnt + AC_W'(1);
            end else if (state == GAP && gap_end) begin
                acq_cnt <= '0;
            end

            if (state == GAP) begin
                gap_cnt <= gap_end ? '0 : gap_cnt + GC_W'(1);
            end

            if (state == GAP && gap_end) begin
                pass_idx <= (pass_idx == PASS_W'(PASS_NUM - 1)) ? '0 : pass_idx + PASS_W'(1);
            end
        end
    end

    // Registered stream outputs; data holds its last value while wrEn is low.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wr_en_q      <= 1'b0;
            data_q       <= '0;
            pass_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wr_en_q      <= (state == SEND);
            if (state == SEND) begin
                data_q <= word_dat;
            end
            pass_done_q  <= (state == GAP) && (gap_cnt == '0);
            frame_done_q <= (state == GAP) && (gap_cnt == '0) &&
                            (pass_idx == PASS_W'(PASS_NUM - 1));
        end
    end

    // Sticky drop flag: a snapshot offered while the shadow is occupied is lost.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            overflow_q <= 1'b0;
        end else if (s.acqValid && full) begin
            overflow_q <= 1'b1;
        end
    end

    assign s.acqReady  = ~full;
    assign s.wrEn      = wr_en_q;
    assign s.data      = data_q;
    assign s.passIdx   = pass_idx;
    assign s.passDone  = pass_done_q;
    assign s.frameDone = frame_done_q;
    assign s.overflow  = overflow_q;
    assign s.busy      = (state != IDLE) || full;

endmodule

// File: tb/tb_tdc_stream_tx.sv
// Self-checking bench for tdc_stream_tx: directed scenarios plus randomized snapshots vs a queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_tdc_stream_tx;
    import tdc_stream_tx_pkg::*;

    typedef struct {
        logic [NP-1:0] word;
        int            pass;
        bit            last_pass;
        bit            last_frame;
    } exp_t;

    logic clk = 1'b0;
    logic res;

    tdc_stream_tx_if bus();

    tdc_stream_tx dut (
        .clk (clk),
        .res (res),
        .s   (bus)
    );

    always #5 clk = ~clk;

    int   n_chk    = 0;
    int   n_err    = 0;
    exp_t q[$];
    int   n_acq    = 0;
    bit   pd_due   = 1'b0;
    bit   fd_due   = 1'b0;
    int   gap_left = 0;
    int   fd_cnt   = 0;
    int   single_w [WORDS_PER_ACQ] = '{108, 511, 1022, 1022, 200, 90};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected stream for one accepted snapshot: pixel-major, then data index.
    task automatic model_push(input logic [ACQ_W-1:0] d);
        int pass;
        pass = (n_acq / ACQ_NUM) % PASS_NUM;
        for (int p = 0; p < PIXEL_NUM; p++) begin
            for (int dd = 0; dd < DATA_NUM; dd++) begin
                exp_t e;
                int   idx;
                idx          = p * DATA_NUM + dd;
                e.word       = d[idx*NP +: NP];
                e.pass       = pass;
                e.last_pass  = (p == PIXEL_NUM - 1) && (dd == DATA_NUM - 1) &&
                               ((n_acq % ACQ_NUM) == ACQ_NUM - 1);
                e.last_frame = e.last_pass && (pass == PASS_NUM - 1);
                q.push_back(e);
            end
        end
        n_acq++;
    endtask

    function automatic logic [ACQ_W-1:0] rand_snap();
        logic [ACQ_W-1:0] r;
        r = '0;
        for (int i = 0; i < WORDS_PER_ACQ; i++) begin
            r[i*NP +: NP] = ($urandom_range(0, 7) == 0) ? {NP{1'b1}}
                                                         : NP'($urandom_range(0, (1 << NP) - 1));
        end
        return r;
    endfunction

    // Stream monitor: data/passIdx order, pass/frame pulses and the post-pass gap.
    always @(negedge clk) begin
        if (res === 1'b0) begin
            if (bus.passDone || pd_due) chk("passDone", bus.passDone, pd_due);
            if (bus.frameDone || fd_due) chk("frameDone", bus.frameDone, fd_due);
            if (bus.frameDone) fd_cnt++;
            if (gap_left > 0) begin
                chk("gap_wrEn", bus.wrEn, 0);
                gap_left--;
            end
            pd_due = 1'b0;
            fd_due = 1'b0;
            if (bus.wrEn) begin
                chk("word_expected", (q.size() > 0), 1);
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("data", bus.data, e.word);
                    chk("passIdx", bus.passIdx, e.pass);
                    if (e.last_pass) begin
                        pd_due   = 1'b1;
                        fd_due   = e.last_frame;
                        gap_left = GAP_CYCLES;
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [ACQ_W-1:0] d, input bit exp_acc);
        @(negedge clk);
        chk("acqReady", bus.acqReady, exp_acc);
        bus.acqValid = 1'b1;
        bus.acqData  = d;
        if (exp_acc) model_push(d);
        @(posedge clk);
        #1;
        bus.acqValid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        res          = 1'b1;
        bus.acqValid = 1'b0;
        q.delete();
        n_acq    = 0;
        pd_due   = 1'b0;
        fd_due   = 1'b0;
        gap_left = 0;
        fd_cnt   = 0;
        #1;
        chk("rst_wrEn", bus.wrEn, 0);
        chk("rst_data", bus.data, 0);
        chk("rst_passIdx", bus.passIdx, 0);
        chk("rst_passDone", bus.passDone, 0);
        chk("rst_frameDone", bus.frameDone, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_busy", bus.busy, 0);
        @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        chk("rst_acqReady", bus.acqReady, 1);
    endtask

    // Edges from accept to first word, then length of the contiguous wrEn run.
    task automatic measure(input int exp_lat, input int exp_run);
        int k;
        int run;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.wrEn && k < 40);
        chk("latency", k - 1, exp_lat);
        run = 0;
        while (bus.wrEn && run < 40) begin
            run++;
            @(negedge clk);
        end
        chk("run_len", run, exp_run);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q.size() != 0 || gap_left != 0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("drain_pending_words", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [ACQ_W-1:0] d;
        logic [ACQ_W-1:0] d2;
        res          = 1'b1;
        bus.acqValid = 1'b0;
        bus.acqData  = '0;

        // Single snapshot with known words.
        do_reset();
        d = '0;
        for (int i = 0; i < WORDS_PER_ACQ; i++) d[i*NP +: NP] = single_w[i][NP-1:0];
        send(d, 1'b1);
        measure(2, WORDS_PER_ACQ);
        drain();
        chk("busy_after_single", bus.busy, 0);

        // Back-to-back: second snapshot accepted while the first streams.
        do_reset();
        d  = rand_snap();
        d2 = rand_snap();
        send(d, 1'b1);
        fork
            begin
                repeat (2) @(negedge clk);
                send(d2, 1'b1);
            end
            measure(2, 2 * WORDS_PER_ACQ);
        join
        drain();

        // Full frame: two passes of two acquisitions.
        do_reset();
        for (int i = 0; i < ACQ_NUM * PASS_NUM; i++) begin
            send(rand_snap(), 1'b1);
            wait_cyc(13);
        end
        drain();
        chk("passIdx_wrap", bus.passIdx, 0);
        chk("frameDone_count", fd_cnt, 1);
        chk("busy_frame_end", bus.busy, 0);

        // Overflow: three offers on consecutive cycles while streaming.
        do_reset();
        send(rand_snap(), 1'b1);
        wait_cyc(2);
        send(rand_snap(), 1'b1);
        send(rand_snap(), 1'b0);
        send(rand_snap(), 1'b0);
        @(negedge clk);
        chk("overflow_set", bus.overflow, 1);
        drain();
        chk("overflow_sticky", bus.overflow, 1);
        send(rand_snap(), 1'b1);
        drain();
        chk("overflow_sticky2", bus.overflow, 1);

        // Reset during word 3 of a pass-1 acquisition.
        do_reset();
        send(rand_snap(), 1'b1);
        wait_cyc(13);
        send(rand_snap(), 1'b1);
        wait_cyc(13);
        send(rand_snap(), 1'b1);
        wait_cyc(4);
        do_reset();
        send(rand_snap(), 1'b1);
        drain();

        // Boundary codes pass through untouched.
        do_reset();
        send({ACQ_W{1'b1}}, 1'b1);
        wait_cyc(13);
        send({ACQ_W{1'b0}}, 1'b1);
        drain();

        // Randomized snapshots at intervals that never overflow.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            send(rand_snap(), 1'b1);
            wait_cyc($urandom_range(11, 19));
        end
        drain();
        chk("overflow_random", bus.overflow, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tdc_stream_tx.md
Name: tdc_stream_tx

Overview:
- Transmit end of the histogram-builder write interface: serializes parallel per-acquisition TDC timestamp snapshots into the one-word-per-cycle wrEn/data stream that the histogram FSM consumes.
- Order within each acquisition is pixel-major, then data index. It emits ACQ_NUM acquisitions per histogram pass and PASS_NUM passes per frame (coarse then fine), with idle gaps between passes.
- Sits between the TDC array capture logic and the histogram builder. A double buffer decouples capture from streaming.

Parameters:
- NP, 10, timestamp width in bits (matches `Np).
- PIXEL_NUM, 3, pixels per acquisition snapshot.
- DATA_NUM, 2, timestamps per pixel per acquisition.
- ACQ_NUM, 2, acquisitions per histogram pass.
- PASS_NUM, 2, histogram passes per frame.
- GAP_CYCLES, 4, idle cycles (wrEn=0) inserted after each pass; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  asynchronous, active-high reset.
- acqValid  in  1  snapshot on acqData is valid.
- acqReady  out  1  shadow buffer free; a snapshot is accepted on the edge where acqValid&&acqReady.
- acqData  in  PIXEL_NUM*DATA_NUM*NP  word (p,d) located at [(p*DATA_NUM+d)*NP +: NP].
- wrEn  out  1  stream word valid; the histogram builder has no backpressure.
- data  out  NP  stream timestamp.
- passIdx  out  clog2(PASS_NUM) (min 1)  pass currently being streamed.
- passDone  out  1  one-cycle pulse, the cycle after the last word of a pass.
- frameDone  out  1  one-cycle pulse, coincident with passDone of the last pass.
- overflow  out  1  sticky flag: a snapshot was dropped.
- busy  out  1  FSM not in IDLE, or shadow buffer full.

Behaviour:
- Reset (async, immediate):
  - wrEn=0, data=0, passIdx=0, passDone=0, frameDone=0, overflow=0, busy=0.
  - Both buffers are emptied, counters cleared, state=IDLE.
  - acqReady=1 once res deasserts.
  - Reset mid-stream discards all in-flight words; the next word after reset belongs to pass 0, acquisition 0.
- Buffers:
  - shadow: one snapshot plus a full flag.
  - active: one snapshot being streamed.
  - acqReady = ~shadowFull. It is purely registered, with no combinational path from acqValid.
- Drop rule: acqValid=1 while acqReady=0 → snapshot discarded and overflow←1 until reset. Stream content is unaffected.
- FSM states:
  - IDLE: if shadowFull, move shadow→active, clear shadowFull, set wordCnt=0, go to SEND.
  - SEND: each cycle register data=active[wordCnt] and wrEn=1, then wordCnt++.
    - On the last word (wordCnt=PIXEL_NUM*DATA_NUM-1), acqCnt++.
    - If acqCnt reached ACQ_NUM-1, go to GAP.
    - Else if shadowFull, transfer shadow→active in the same edge and stay in SEND with no bubble.
    - Else go to IDLE.
  - GAP: wrEn=0 for exactly GAP_CYCLES cycles.
    - passDone pulses in the first GAP cycle; frameDone also pulses there if passIdx=PASS_NUM-1.
    - On exit: acqCnt=0; passIdx wraps to 0 after PASS_NUM-1, else increments; go to IDLE.
    - The shadow may be filled during GAP; it is held until IDLE.
- Simultaneous shadow→active transfer and a new accept on the same edge: not possible, since acqReady=0 whenever shadowFull. After the transfer edge, acqReady returns to 1 the next cycle.
- Latency: accept at edge t with FSM in IDLE and shadow empty → transfer at edge t+1 → first wrEn=1 cycle follows edge t+2.
- Throughput: 1 word/clk while in SEND. Snapshots arriving at an interval ≥ PIXEL_NUM*DATA_NUM cycles never overflow within a pass.
- data holds its last value when wrEn=0. Consumers must ignore data when wrEn=0.
- Timestamps pass through unmodified, including all-ones (no-photon) codes.

Decomposition:
- Shared package (extend existing parameter header):
  - constants NP, PIXEL_NUM, DATA_NUM, ACQ_NUM, PASS_NUM, GAP_CYCLES;
  - derived WORDS_PER_ACQ=PIXEL_NUM*DATA_NUM;
  - state enum {IDLE, SEND, GAP}.
- Sub-module acq_dbuf: shadow/active double buffer with full flag, accept/transfer controls, and a word-select mux by wordCnt.
- The top level holds the FSM, counters and pulse generation.

Test Plan:
- Single snapshot: reset, then one acqValid with words p0d0..p2d1 = 108,511,1022,1022,200,90 → wrEn high 6 consecutive cycles starting 2 cycles after accept, data in that order, then idle.
- Back-to-back: second snapshot accepted while the first is streaming → 12 contiguous wrEn cycles with no bubble; passDone pulses once, the cycle after word 12; then exactly 4 wrEn=0 GAP cycles.
- Full frame: 4 snapshots (2 passes × 2 acqs) → passIdx goes 0 then 1; frameDone pulses once, coincident with the second passDone; passIdx returns to 0.
- Overflow: assert 3 snapshots on consecutive cycles while SEND is busy → third is dropped, overflow=1 and stays 1; streamed words match only the first two snapshots.
- Mid-stream reset: pulse res during word 3 of a pass-1 acquisition → wrEn=0 immediately, all outputs at reset values; the next snapshot streams as pass 0, acq 0.
- Boundary passthrough: snapshot of all 1023 and all 0 words → output identical, no truncation of the NP=10 bits.
